// File: rtl/ariane_pkg.sv
// Shared constants for the writeback round-robin arbiter.
package ariane_pkg;

  localparam int unsigned WB_ARB_NR_FU = 4;
  localparam int unsigned WB_ARB_DEPTH = 2;

  // Next channel index after idx, wrapping n-1 back to 0.
  function automatic int unsigned wb_arb_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Single-channel result FIFO for the writeback arbiter.
// Full/empty come from a registered count only, so the producer-side
// ready has no combinational dependency on the pop side. A full FIFO
// refuses a push even in a cycle where it pops. Flush empties the FIFO
// and drops any push in the same cycle.
module wb_arb_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = WB_ARB_DEPTH,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;

  logic w_push;
  logic w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (r_cnt == CNT_W'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i & ~full_o & ~flush_i;
  assign w_pop   = pop_i & ~empty_o & ~flush_i;
  assign data_o  = r_mem[r_rptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the data array has no reset; an entry is only observable after it
  // has been written, so resetting it would only cost flops.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin writeback arbiter: NR_FU producer channels, each buffered
// in a private wb_arb_fifo, share one scoreboard writeback port.
// A grant stalled by wb_ready_i=0 is locked until it completes so the
// writeback payload stays stable.
// Optional: define WB_RR_ARBITER_PERF_EN to add per-channel stall counters
// on perf_stall_cnt_o.
module wb_rr_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_FU         = WB_ARB_NR_FU,
  parameter int unsigned DEPTH         = WB_ARB_DEPTH,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned CAUSE_W       = 64,
  localparam int unsigned IDX_W        = $clog2(NR_FU)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [NR_FU-1:0]               fu_valid_i,
  output logic [NR_FU-1:0]               fu_ready_o,
  input  logic [NR_FU*XLEN-1:0]          fu_result_i,
  input  logic [NR_FU*TRANS_ID_BITS-1:0] fu_trans_id_i,
  input  logic [NR_FU-1:0]               fu_ex_valid_i,
  input  logic [NR_FU*CAUSE_W-1:0]       fu_ex_cause_i,
  output logic                           wb_valid_o,
  input  logic                           wb_ready_i,
  output logic [XLEN-1:0]                wb_result_o,
  output logic [TRANS_ID_BITS-1:0]       wb_trans_id_o,
  output logic                           wb_ex_valid_o,
  output logic [CAUSE_W-1:0]             wb_ex_cause_o,
  output logic [IDX_W-1:0]               wb_fu_idx_o
`ifdef WB_RR_ARBITER_PERF_EN
  ,
  output logic [NR_FU*32-1:0]            perf_stall_cnt_o
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic                     ex_valid;
    logic [CAUSE_W-1:0]       ex_cause;
  } entry_t;

  entry_t           w_fu_entry [NR_FU];
  entry_t           w_head     [NR_FU];
  entry_t           w_sel;
  logic [NR_FU-1:0] w_full;
  logic [NR_FU-1:0] w_empty;
  logic [NR_FU-1:0] w_push;
  logic [NR_FU-1:0] w_pop;

  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_lock;
  logic [IDX_W-1:0] r_lock_idx;

  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_rr_idx;
  logic             w_rr_found;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_any;
  logic             w_wb_valid;
  logic             w_handshake;

  for (genvar i = 0; i < NR_FU; i++) begin : g_chan
    assign w_fu_entry[i] = '{
      result:   fu_result_i[i*XLEN +: XLEN],
      trans_id: fu_trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS],
      ex_valid: fu_ex_valid_i[i],
      ex_cause: fu_ex_cause_i[i*CAUSE_W +: CAUSE_W]
    };
    assign w_push[i] = fu_valid_i[i] & ~w_full[i];

    wb_arb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (w_push[i]),
      .pop_i   (w_pop[i]),
      .data_i  (w_fu_entry[i]),
      .data_o  (w_head[i]),
      .full_o  (w_full[i]),
      .empty_o (w_empty[i])
    );
  end

  assign fu_ready_o = ~w_full;

  // Round-robin search: first non-empty channel at or after r_rr_ptr.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_cand     = '0;
    w_rr_idx   = '0;
    w_rr_found = 1'b0;
    for (int k = 0; k < NR_FU; k++) begin
      w_cand = IDX_W'((32'(r_rr_ptr) + 32'(k)) % NR_FU);
      if (!w_rr_found && !w_empty[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand;
      end
    end
  end

  assign w_any       = |(~w_empty);
  assign w_grant_idx = r_lock ? r_lock_idx : w_rr_idx;
  assign w_wb_valid  = w_any & ~flush_i;
  assign w_handshake = w_wb_valid & wb_ready_i;

  // Pop strobe for the granted channel and the zero-when-idle payload mux.
  always_comb begin
    w_pop              = '0;
    w_pop[w_grant_idx] = w_handshake;
    w_sel              = w_wb_valid ? w_head[w_grant_idx] : '0;
  end

  assign wb_valid_o    = w_wb_valid;
  assign wb_result_o   = w_sel.result;
  assign wb_trans_id_o = w_sel.trans_id;
  assign wb_ex_valid_o = w_sel.ex_valid;
  assign wb_ex_cause_o = w_sel.ex_cause;
  assign wb_fu_idx_o   = w_wb_valid ? w_grant_idx : '0;

  // Round-robin pointer advance and stall lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (flush_i) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      if (w_handshake) begin
        r_rr_ptr <= IDX_W'(wb_arb_wrap_inc(32'(w_grant_idx), NR_FU));
      end
      r_lock <= w_wb_valid & ~wb_ready_i;
      if (w_wb_valid && !wb_ready_i) r_lock_idx <= w_grant_idx;
    end
  end

`ifdef WB_RR_ARBITER_PERF_EN
  logic [31:0] r_stall_cnt [NR_FU];

  // Saturating per-channel count of cycles holding data without a pop;
  // only reset clears it, and the flush cycle itself is not counted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_FU; i++) r_stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NR_FU; i++) begin
        if (!w_empty[i] && !w_pop[i] && !flush_i && (r_stall_cnt[i] != '1)) begin
          r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < NR_FU; i++) begin : g_perf
    assign perf_stall_cnt_o[i*32 +: 32] = r_stall_cnt[i];
  end
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (default parameters).
// Expected writebacks are queued when the producer side is driven and
// compared against the writeback port when it presents them.
module tb_wb_rr_arbiter;

  localparam int NR_FU = 4;
  localparam int XLEN  = 64;
  localparam int TIDW  = 3;
  localparam int CW    = 64;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   flush_i;
  logic [NR_FU-1:0]       fu_valid_i;
  logic [NR_FU-1:0]       fu_ready_o;
  logic [NR_FU*XLEN-1:0]  fu_result_i;
  logic [NR_FU*TIDW-1:0]  fu_trans_id_i;
  logic [NR_FU-1:0]       fu_ex_valid_i;
  logic [NR_FU*CW-1:0]    fu_ex_cause_i;
  logic                   wb_valid_o;
  logic                   wb_ready_i;
  logic [XLEN-1:0]        wb_result_o;
  logic [TIDW-1:0]        wb_trans_id_o;
  logic                   wb_ex_valid_o;
  logic [CW-1:0]          wb_ex_cause_o;
  logic [1:0]             wb_fu_idx_o;
`ifdef WB_RR_ARBITER_PERF_EN
  logic [NR_FU*32-1:0]    perf_stall_cnt_o;
`endif

  wb_rr_arbiter dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .fu_valid_i    (fu_valid_i),
    .fu_ready_o    (fu_ready_o),
    .fu_result_i   (fu_result_i),
    .fu_trans_id_i (fu_trans_id_i),
    .fu_ex_valid_i (fu_ex_valid_i),
    .fu_ex_cause_i (fu_ex_cause_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_result_o   (wb_result_o),
    .wb_trans_id_o (wb_trans_id_o),
    .wb_ex_valid_o (wb_ex_valid_o),
    .wb_ex_cause_o (wb_ex_cause_o),
    .wb_fu_idx_o   (wb_fu_idx_o)
`ifdef WB_RR_ARBITER_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]      idx;
    logic [XLEN-1:0] res;
    logic [TIDW-1:0] id;
    logic            exv;
    logic [CW-1:0]   cause;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled one time unit later.
  task automatic next();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input int ch, input logic [XLEN-1:0] res, input logic [TIDW-1:0] id,
                       input logic exv, input logic [CW-1:0] cause);
    fu_valid_i[ch]                  = 1'b1;
    fu_result_i[ch*XLEN +: XLEN]    = res;
    fu_trans_id_i[ch*TIDW +: TIDW]  = id;
    fu_ex_valid_i[ch]               = exv;
    fu_ex_cause_i[ch*CW +: CW]      = cause;
  endtask

  task automatic sb_push(input int ch, input logic [XLEN-1:0] res, input logic [TIDW-1:0] id,
                         input logic exv, input logic [CW-1:0] cause);
    exp_t e;
    e.idx = 2'(ch); e.res = res; e.id = id; e.exv = exv; e.cause = cause;
    sb_q.push_back(e);
  endtask

  // Compare the writeback port with the oldest expected entry; retire it
  // when this cycle is a handshake.
  task automatic wb_expect(input string tag, input logic do_pop);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q[0];
      check({tag, "_valid"}, 64'(wb_valid_o), 64'd1);
      check({tag, "_idx"},   64'(wb_fu_idx_o), 64'(e.idx));
      check({tag, "_res"},   wb_result_o, e.res);
      check({tag, "_id"},    64'(wb_trans_id_o), 64'(e.id));
      check({tag, "_exv"},   64'(wb_ex_valid_o), 64'(e.exv));
      check({tag, "_cause"}, wb_ex_cause_o, e.cause);
      if (do_pop) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    fu_valid_i    = '0;
    fu_result_i   = '0;
    fu_trans_id_i = '0;
    fu_ex_valid_i = '0;
    fu_ex_cause_i = '0;
    wb_ready_i    = 1'b0;

    // Reset state
    #3;
    check("rst_valid",  64'(wb_valid_o), 64'd0);
    check("rst_ready",  64'(fu_ready_o), 64'hF);
    check("rst_res",    wb_result_o, 64'd0);
    check("rst_id",     64'(wb_trans_id_o), 64'd0);
    check("rst_exv",    64'(wb_ex_valid_o), 64'd0);
    check("rst_cause",  wb_ex_cause_o, 64'd0);
    check("rst_idx",    64'(wb_fu_idx_o), 64'd0);
    next(); next();
    rst_ni = 1'b1;
    next(); #1;
    check("idle_valid", 64'(wb_valid_o), 64'd0);
    check("idle_ready", 64'(fu_ready_o), 64'hF);

    // Single push on ch2, one-cycle latency, no bypass
    next();
    wb_ready_i = 1'b1;
    drive(2, 64'hDEAD, 3'd5, 1'b0, '0);
    sb_push(2, 64'hDEAD, 3'd5, 1'b0, '0);
    #1 check("t2_no_bypass", 64'(wb_valid_o), 64'd0);
    next();
    fu_valid_i = '0;
    #1 wb_expect("t2_wb", 1'b1);
    next(); #1;
    check("t2_drained", 64'(wb_valid_o), 64'd0);

    // Flush an empty arbiter to bring rr_ptr back to 0
    next();
    flush_i = 1'b1;
    #1 check("t3_flush_valid", 64'(wb_valid_o), 64'd0);

    // All four channels at once -> grants 0,1,2,3
    next();
    flush_i = 1'b0;
    for (int c = 0; c < NR_FU; c++) begin
      drive(c, 64'h1000 + 64'(c), 3'(c), 1'b0, '0);
      sb_push(c, 64'h1000 + 64'(c), 3'(c), 1'b0, '0);
    end
    #1 check("t3_latency", 64'(wb_valid_o), 64'd0);
    for (int c = 0; c < NR_FU; c++) begin
      next();
      fu_valid_i = '0;
      #1 wb_expect("t3_rr", 1'b1);
    end

    // Refill ch0 and ch3 (ch3 carries an exception) -> 0 first after wrap
    next();
    drive(0, 64'h2000, 3'd6, 1'b0, '0);
    drive(3, 64'h3000, 3'd7, 1'b1, 64'hC0FFEE);
    sb_push(0, 64'h2000, 3'd6, 1'b0, '0);
    sb_push(3, 64'h3000, 3'd7, 1'b1, 64'hC0FFEE);
    #1 check("t3_refill_empty", 64'(wb_valid_o), 64'd0);
    next();
    fu_valid_i = '0;
    #1 wb_expect("t3_wrap0", 1'b1);
    next(); #1;
    wb_expect("t3_wrap3", 1'b1);

    // Backpressure: ch1 locked for 3 stalled cycles while ch0 fills
    next();
    wb_ready_i = 1'b0;
    drive(1, 64'h111, 3'd1, 1'b0, '0);
    sb_push(1, 64'h111, 3'd1, 1'b0, '0);
    #1 check("t4_pre", 64'(wb_valid_o), 64'd0);
    next();
    fu_valid_i = '0;
    drive(0, 64'h100, 3'd2, 1'b0, '0);
    sb_push(0, 64'h100, 3'd2, 1'b0, '0);
    #1 wb_expect("t4_stall1", 1'b0);
    next();
    fu_valid_i = '0;
    #1 wb_expect("t4_stall2", 1'b0);
    next(); #1;
    wb_expect("t4_stall3", 1'b0);
    next();
    wb_ready_i = 1'b1;
    #1 wb_expect("t4_pop1", 1'b1);
    next(); #1;
    wb_expect("t4_pop0", 1'b1);

    // ch1 fill: ready drops after DEPTH pushes, third push refused
    next();
    wb_ready_i = 1'b0;
    drive(1, 64'hA1, 3'd3, 1'b0, '0);
    #1 check("t4_full_rdy0", 64'(fu_ready_o[1]), 64'd1);
    next();
    drive(1, 64'hA2, 3'd4, 1'b0, '0);
    #1 check("t4_full_rdy1", 64'(fu_ready_o[1]), 64'd1);
    next();
    drive(1, 64'hA3, 3'd5, 1'b0, '0);
    #1 check("t4_full_rdy2", 64'(fu_ready_o[1]), 64'd0);
    check("t4_full_head", wb_result_o, 64'hA1);

    // Flush with 2 entries in ch0, 1 in ch3, 2 in ch1, push on ch2 dropped
    next();
    fu_valid_i = '0;
    drive(0, 64'hB0, 3'd0, 1'b0, '0);
    drive(3, 64'hB3, 3'd3, 1'b0, '0);
    next();
    fu_valid_i = '0;
    drive(0, 64'hB1, 3'd1, 1'b0, '0);
    next();
    fu_valid_i = '0;
    flush_i    = 1'b1;
    wb_ready_i = 1'b1;
    drive(2, 64'hB2, 3'd2, 1'b0, '0);
    #1 check("t5_flush_valid", 64'(wb_valid_o), 64'd0);
    check("t5_flush_res", wb_result_o, 64'd0);
    next();
    flush_i    = 1'b0;
    fu_valid_i = '0;
    #1 check("t5_ready", 64'(fu_ready_o), 64'hF);
    for (int c = 0; c < 4; c++) begin
      check("t5_quiet", 64'(wb_valid_o), 64'd0);
      next(); #1;
    end

    // Asynchronous reset in the middle of a cycle with traffic pending
    wb_ready_i = 1'b0;
    drive(2, 64'hC0, 3'd0, 1'b0, '0);
    next();
    drive(2, 64'hC1, 3'd1, 1'b0, '0);
    next();
    fu_valid_i = '0;
    #1 check("t1_pre_valid", 64'(wb_valid_o), 64'd1);
    check("t1_pre_ready", 64'(fu_ready_o), 64'hB);
    #1 rst_ni = 1'b0;
    #1 check("t1_async_valid", 64'(wb_valid_o), 64'd0);
    check("t1_async_ready", 64'(fu_ready_o), 64'hF);
    check("t1_async_idx", 64'(wb_fu_idx_o), 64'd0);
    check("t1_async_res", wb_result_o, 64'd0);
    next();
    rst_ni = 1'b1;
    next(); #1;
    check("t1_after_valid", 64'(wb_valid_o), 64'd0);

`ifdef WB_RR_ARBITER_PERF_EN
    // ch3 waits behind a stalled ch0 grant for 5 cycles
    next();
    wb_ready_i = 1'b0;
    drive(0, 64'hD0, 3'd0, 1'b0, '0);
    drive(3, 64'hD3, 3'd3, 1'b0, '0);
    for (int c = 0; c < 5; c++) begin
      next();
      fu_valid_i = '0;
    end
    next();
    flush_i = 1'b1;
    #1 check("t6_perf3", 64'(perf_stall_cnt_o[3*32 +: 32]), 64'd5);
    next();
    flush_i = 1'b0;
    #1 check("t6_perf3_flush", 64'(perf_stall_cnt_o[3*32 +: 32]), 64'd5);
`endif

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Parametrised successor to the execute-stage fixed-priority result mux.
- Accepts results from NR_FU functional-unit channels, each with its own ready/valid handshake.
- Buffers each channel in a private FIFO and arbitrates them round-robin onto one scoreboard writeback port, with backpressure.
- Replaces the static priority selection (ALU > CSR > MULT), so a stalled or low-priority unit is never starved and units need not be issue-scheduled to avoid port collisions.

Parameters:
- NR_FU, 4, number of producer channels (>=2).
- DEPTH, 2, entries per channel FIFO (power of 2, >=1; DEPTH>=2 needed for one result per cycle per channel).
- XLEN, 64, result width.
- TRANS_ID_BITS, 3, scoreboard transaction id width.
- CAUSE_W, 64, exception cause width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous pipeline flush
- fu_valid_i  in  NR_FU  per-channel result valid
- fu_ready_o  out  NR_FU  per-channel FIFO not full
- fu_result_i  in  NR_FU*XLEN  per-channel result
- fu_trans_id_i  in  NR_FU*TRANS_ID_BITS  per-channel scoreboard id
- fu_ex_valid_i  in  NR_FU  per-channel exception flag
- fu_ex_cause_i  in  NR_FU*CAUSE_W  per-channel exception cause
- wb_valid_o  out  1  writeback valid
- wb_ready_i  in  1  scoreboard accepts writeback
- wb_result_o  out  XLEN  granted result
- wb_trans_id_o  out  TRANS_ID_BITS  granted id
- wb_ex_valid_o  out  1  granted exception flag
- wb_ex_cause_o  out  CAUSE_W  granted cause
- wb_fu_idx_o  out  $clog2(NR_FU)  index of the granted channel

Behaviour:
- Reset (rst_ni low, asynchronous): all FIFOs empty, pointers 0, rr pointer 0, lock cleared.
  - Resulting outputs: wb_valid_o=0, fu_ready_o=all 1, wb_* data outputs=0, wb_fu_idx_o=0.
- Push: channel i writes when fu_valid_i[i] & fu_ready_o[i].
  - fu_ready_o[i] = !full[i], taken from registered count only; there is no combinational path from wb_ready_i or fu_valid_i to fu_ready_o.
  - A full FIFO does not accept a push in the same cycle it pops.
- Latency: an entry pushed in cycle t is presentable on wb_* in cycle t+1 at the earliest. There is no bypass.
- Arbitration: among non-empty FIFOs, grant the first index >= rr_ptr, wrapping modulo NR_FU.
  - wb_valid_o = any non-empty.
  - wb_* outputs are the head of the granted FIFO; with no grant they are driven 0.
- Pop and pointer update: on wb_valid_o & wb_ready_i, pop the granted FIFO and set rr_ptr = granted+1, wrapping NR_FU-1 -> 0.
- Lock: if wb_valid_o=1 and wb_ready_i=0, the grant is registered and held until the handshake, even if lower-index or newly filled FIFOs become non-empty.
  - wb_* must stay stable while stalled.
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance.
- Flush (flush_i=1):
  - All FIFOs cleared, lock cleared, rr_ptr=0.
  - Pushes in the flush cycle are dropped.
  - wb_valid_o is forced 0 in that cycle; no pop occurs.
  - fu_ready_o=all 1 from the next cycle.
- Ordering: FIFO order is preserved within a channel; there is no ordering guarantee across channels (the scoreboard uses trans_id).
- Exceptions are carried unmodified; an exception entry is arbitrated like any other.

Optional Feature:
- Macro: WB_RR_ARBITER_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt_o, NR_FU*32 bits.
  - Counter i increments, saturating at 2^32-1, on every cycle FIFO i is non-empty and not popped.
  - Counters clear on reset only; flush does not clear them.
- Undefined: the port and counters do not exist. The behaviour above is otherwise identical.

Decomposition:
- ariane_pkg holds the default constants: WB_ARB_NR_FU=4, WB_ARB_DEPTH=2.
- The entry struct (result, trans_id, ex_valid, ex_cause) is declared locally from the parameters.
- One sub-module, wb_arb_fifo: parametrised single-channel FIFO with push, pop, flush, full, empty and head outputs, instantiated NR_FU times.
- The round-robin grant and lock logic stay in the top level.

Test Plan:
1. Reset, then all channels idle -> wb_valid_o=0, fu_ready_o=4'b1111. Assert rst_ni low mid-traffic -> same values immediately, without waiting for a clock edge.
2. Single push on ch2 in cycle t (result=64'hDEAD, id=5), wb_ready_i=1:
   - cycle t+1: wb_valid_o=1, wb_fu_idx_o=2, wb_result_o=64'hDEAD, wb_trans_id_o=5.
   - cycle t+2: wb_valid_o=0.
3. All four channels push together, wb_ready_i=1 -> grants 0,1,2,3 in consecutive cycles. Then refill ch0 and ch3 -> next grant is 0, since rr_ptr wrapped to 0 after granting 3.
4. Backpressure:
   - ch1 pending, wb_ready_i=0 for 3 cycles, ch0 pushes meanwhile -> wb_fu_idx_o stays 1 and data stays stable.
   - Then wb_ready_i=1 -> ch1 pops, ch0 is granted the next cycle.
   - ch1 pushing 3 entries with DEPTH=2 and no pops -> fu_ready_o[1]=0 after 2 pushes.
5. Flush with 2 entries in ch0 and 1 in ch3, plus a push on ch2 in the flush cycle -> wb_valid_o=0 in the flush cycle and every cycle after, none of those entries is ever written back, fu_ready_o=all 1.
6. With WB_RR_ARBITER_PERF_EN: ch3 held non-empty behind a stalled ch0 grant for 5 cycles -> perf_stall_cnt_o[3]=5. A subsequent flush leaves it at 5.
